// File: rtl/alu_issue.sv
// alu_issue: two-stage issue pipeline (operand register A, result register B) between decoder, ALU and writeback.
// Define ALU_ISSUE_WORD_OPS_EN to compile in RV64 W-operation operand/result handling.
module alu_issue (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        dec_valid_i,
    output logic        dec_ready_o,
    input  logic [3:0]  dec_op_i,
    input  logic [63:0] dec_rs1_i,
    input  logic [63:0] dec_rs2_i,
    input  logic [63:0] dec_imm_i,
    input  logic [63:0] dec_pc_i,
    input  logic        dec_sel1_i,
    input  logic        dec_sel2_i,
    input  logic [4:0]  dec_rd_i,
    input  logic        dec_word_i,
    output logic [3:0]  alu_op_o,
    output logic [63:0] alu_in1_o,
    output logic [63:0] alu_in2_o,
    input  logic [63:0] alu_result_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [63:0] wb_data_o
);
    localparam logic [3:0] ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
`ifdef ALU_ISSUE_WORD_OPS_EN
    localparam bit WORD_OPS = 1'b1;
`else
    localparam bit WORD_OPS = 1'b0;
`endif
    logic        a_valid, b_valid, a_word, a_adv, dec_fire, w, shift;
    logic [3:0]  a_op;
    logic [4:0]  a_rd, b_rd;
    logic [63:0] a_in1, a_in2, b_data, op1, op2, in1_n, in2_n, res_n;
    always_comb begin
        a_adv    = a_valid & (~b_valid | wb_ready_i);
        dec_fire = dec_valid_i & dec_ready_o;
        op1      = dec_sel1_i ? dec_pc_i : dec_rs1_i;
        op2      = dec_sel2_i ? dec_imm_i : dec_rs2_i;
        w        = WORD_OPS & dec_word_i;
        shift    = (dec_op_i == ALU_SLL) | (dec_op_i == ALU_SRL) | (dec_op_i == ALU_SRA);
        // W shifts see a 32-bit value: SRL must not shift in the upper half, others sign-extend
        in1_n    = !w ? op1 : (dec_op_i == ALU_SRL) ? {32'b0, op1[31:0]} : {{32{op1[31]}}, op1[31:0]};
        in2_n    = (w && shift) ? {op2[63:6], 1'b0, op2[4:0]} : op2;
        res_n    = (a_rd == 5'd0) ? 64'd0 : a_word ? {{32{alu_result_i[31]}}, alu_result_i[31:0]} : alu_result_i;
    end
    assign dec_ready_o = ~a_valid | a_adv;
    assign alu_op_o    = a_op;
    assign alu_in1_o   = a_in1;
    assign alu_in2_o   = a_in2;
    assign wb_valid_o  = b_valid;
    assign wb_rd_o     = b_rd;
    assign wb_data_o   = b_data;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            b_rd    <= 5'd0;
            b_data  <= 64'd0;
        end else begin
            if (dec_ready_o) a_valid <= dec_valid_i;
            b_valid <= a_adv | (b_valid & ~wb_ready_i);
            if (a_adv) begin
                b_rd   <= a_rd;
                b_data <= res_n;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (dec_fire) begin
            a_op   <= dec_op_i;
            a_in1  <= in1_n;
            a_in2  <= in2_n;
            a_rd   <= dec_rd_i;
            a_word <= w;
        end
    end
endmodule
